// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side skid buffer: depth, pointer and occupancy types.
package fifo_pkg;

    localparam int SKID_DEPTH = 3;

    typedef logic [1:0] skid_ptr_t;
    typedef logic [1:0] skid_occ_t;

    // Pointers cycle 0 -> 1 -> 2 -> 0; value 3 never occurs.
    function automatic skid_ptr_t skid_ptr_inc(input skid_ptr_t ptr);
        return (ptr == skid_ptr_t'(SKID_DEPTH - 1)) ? skid_ptr_t'(0) : ptr + skid_ptr_t'(1);
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Three-entry in-order skid buffer: push at tail, pop at head, clear empties it.
// Clear wins over a same-cycle push.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head_data,
    output skid_occ_t        occ
);

    skid_ptr_t head_reg, head_next;
    skid_ptr_t tail_reg, tail_next;
    skid_occ_t occ_reg, occ_next;
    logic      push_ok;

    logic [SKID_DEPTH-1:0][WIDTH-1:0] entry_data;

    assign push_ok = push && !clear;

    genvar gi;
    generate
        for (gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (push_ok && (tail_reg == skid_ptr_t'(gi))) begin
                    entry_reg <= push_data;
                end
            end

            assign entry_data[gi] = entry_reg;
        end
    endgenerate

    always_comb begin
        head_next = head_reg;
        tail_next = tail_reg;
        occ_next  = occ_reg;
        if (clear) begin
            head_next = '0;
            tail_next = '0;
            occ_next  = '0;
        end else begin
            if (push_ok) begin
                tail_next = skid_ptr_inc(tail_reg);
            end
            if (pop) begin
                head_next = skid_ptr_inc(head_reg);
            end
            case ({push_ok, pop})
                2'b10:   occ_next = occ_reg + skid_occ_t'(1);
                2'b01:   occ_next = occ_reg - skid_occ_t'(1);
                default: occ_next = occ_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg <= '0;
            tail_reg <= '0;
            occ_reg  <= '0;
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
            occ_reg  <= occ_next;
        end
    end

    always_comb begin
        head_data = entry_data[0];
        case (head_reg)
            2'd1:    head_data = entry_data[1];
            2'd2:    head_data = entry_data[2];
            default: head_data = entry_data[0];
        endcase
    end

    assign valid = (occ_reg != '0);
    assign occ   = occ_reg;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side controller for fifo_queue: issues deq, captures data_out one cycle later,
// presents it as a valid/ready stream. Optional FIFO_DRAIN_CNT_EN adds drain_count.
module fifo_drain_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_deq,
    input  logic             flush,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
`ifdef FIFO_DRAIN_CNT_EN
    ,
    output logic [CNT_W-1:0] drain_count
`endif
);

    generate
        if (CNT_W < 1 || WIDTH < 1) begin : g_param_check
            $error("fifo_drain_ctrl: WIDTH and CNT_W must be at least 1");
        end
    endgenerate

    logic      pend_reg, pend_next;
    logic      drop_reg, drop_next;
    skid_occ_t occ;
    logic [2:0] inflight;
    logic      capture;
    logic      pop;

    // Words buffered plus the one on its way; capping this at the depth is what
    // keeps m_ready out of the deq path while still allowing 1 word/clk.
    assign inflight = {1'b0, occ} + {2'b00, pend_reg};
    assign fifo_deq = rst_n && !fifo_empty && !flush && (inflight < 3'(SKID_DEPTH));

    assign capture = pend_reg && !drop_reg;
    assign pop     = m_valid && m_ready;

    // The word arriving on a flush edge is discarded by the buffer clear; drop
    // covers any request still outstanding beyond that edge.
    always_comb begin
        pend_next = fifo_deq;
        drop_next = flush && (pend_reg || fifo_deq);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg <= 1'b0;
            drop_reg <= 1'b0;
        end else begin
            pend_reg <= pend_next;
            drop_reg <= drop_next;
        end
    end

    fifo_rd_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (capture),
        .push_data (fifo_data),
        .pop       (pop),
        .valid     (m_valid),
        .head_data (m_data),
        .occ       (occ)
    );

`ifdef FIFO_DRAIN_CNT_EN
    logic [CNT_W-1:0] cnt_reg;

    // Counts every handshake, including one in a flush cycle; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (pop) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign drain_count = cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: behavioural FIFO source, scoreboard queue, negedge monitor.
// Build with FIFO_DRAIN_CNT_EN defined to also check drain_count.
module tb_fifo_drain_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data = '0;
    logic             fifo_deq;
    logic             flush = 1'b0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] m_data;
`ifdef FIFO_DRAIN_CNT_EN
    logic [CNT_W-1:0] drain_count;
`endif

    int checks = 0;
    int failures = 0;

    logic [WIDTH-1:0] fmem [64];
    int               wr_ptr = 0;
    int               rd_ptr = 0;
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] mon_exp;

    fifo_drain_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_deq   (fifo_deq),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef FIFO_DRAIN_CNT_EN
        ,
        .drain_count (drain_count)
`endif
    );

    always #5 clk = ~clk;

    // Source FIFO: registered data_out, valid the cycle after deq.
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_deq) begin
            if (fifo_empty) begin
                checks++;
                failures++;
                $display("FAIL deq_on_empty actual=1 required=0");
            end else begin
                fifo_data <= fmem[rd_ptr % 64];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    // Scoreboard monitor: one line per accepted word.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected actual=%02h required=none", m_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (m_data !== mon_exp) begin
                    failures++;
                    $display("FAIL sb_data actual=%02h required=%02h", m_data, mon_exp);
                end else begin
                    $display("tx data=%02h", m_data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic load_word(input logic [WIDTH-1:0] v, input bit push_exp);
        fmem[wr_ptr % 64] = v;
        wr_ptr = wr_ptr + 1;
        if (push_exp) exp_q.push_back(v);
    endtask

    task automatic load(input int base, input int n, input bit push_exp);
        for (int i = 0; i < n; i++) load_word(WIDTH'(base + i), push_exp);
    endtask

    task automatic begin_reset(input logic rdy);
        rst_n   = 1'b0;
        flush   = 1'b0;
        m_ready = rdy;
        wr_ptr  = rd_ptr;
        next_cycle();
        next_cycle();
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) next_cycle();
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ndeq;
        next_cycle();

        // 1: two words, reset values, two-cycle latency
        begin_reset(1'b1);
        load_word(8'hA1, 1'b1);
        load_word(8'hB2, 1'b1);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_fifo_deq", fifo_deq, 0);
        chk("rst_m_data", m_data, 0);
`ifdef FIFO_DRAIN_CNT_EN
        chk("rst_drain_count", drain_count, 0);
`endif
        rst_n = 1'b1;
        mid();
        chk("t1_deq_c0", fifo_deq, 1);
        chk("t1_valid_c0", m_valid, 0);
        next_cycle(); mid();
        chk("t1_deq_c1", fifo_deq, 1);
        chk("t1_valid_c1", m_valid, 0);
        next_cycle(); mid();
        chk("t1_valid_c2", m_valid, 1);
        chk("t1_data_c2", m_data, 8'hA1);
        chk("t1_deq_c2", fifo_deq, 0);
        next_cycle(); mid();
        chk("t1_valid_c3", m_valid, 1);
        chk("t1_data_c3", m_data, 8'hB2);
        next_cycle(); mid();
        chk("t1_valid_c4", m_valid, 0);
        wait_drain("t1_drain");

        // 2: full rate streaming
        begin_reset(1'b1);
        load(8'h10, 8, 1'b1);
        rst_n = 1'b1;
        for (int t = 0; t < 12; t++) begin
            mid();
            chk("t2_deq", fifo_deq, !fifo_empty);
            chk("t2_valid", m_valid, (t >= 2 && t <= 9));
            next_cycle();
        end
        wait_drain("t2_drain");

        // 3: backpressure fills the buffer, then release
        begin_reset(1'b0);
        load(8'h10, 8, 1'b1);
        rst_n = 1'b1;
        ndeq = 0;
        for (int t = 0; t < 8; t++) begin
            mid();
            if (fifo_deq) ndeq++;
            if (t >= 2) chk("t3_hold_data", m_data, 8'h10);
            next_cycle();
        end
        chk("t3_deq_count", ndeq, 3);
        chk("t3_deq_off", fifo_deq, 0);
        m_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            mid();
            chk("t3_nogap", m_valid, 1);
            next_cycle();
        end
        wait_drain("t3_drain");

        // 4: flush with occ=2, pend=1; words 20..22 are discarded
        begin_reset(1'b0);
        load(8'h20, 8, 1'b0);
        for (int i = 3; i < 8; i++) exp_q.push_back(WIDTH'(8'h20 + i));
        rst_n = 1'b1;
        next_cycle(); next_cycle(); next_cycle();
        flush = 1'b1;
        mid();
        chk("t4_valid_pre", m_valid, 1);
        chk("t4_deq_flush", fifo_deq, 0);
        next_cycle();
        flush = 1'b0;
        m_ready = 1'b1;
        mid();
        chk("t4_valid_post", m_valid, 0);
        chk("t4_deq_resume", fifo_deq, 1);
        wait_drain("t4_drain");

        // 5: async reset mid-stream, restart from the FIFO's remaining words
        begin_reset(1'b0);
        load(8'h40, 8, 1'b0);
        rst_n = 1'b1;
        next_cycle(); next_cycle(); next_cycle();
        mid();
        rst_n = 1'b0;
        #1;
        chk("t5_valid_rst", m_valid, 0);
        chk("t5_deq_rst", fifo_deq, 0);
        chk("t5_data_rst", m_data, 0);
        next_cycle(); next_cycle();
        m_ready = 1'b1;
        for (int i = 3; i < 8; i++) exp_q.push_back(WIDTH'(8'h40 + i));
        rst_n = 1'b1;
        mid();
        chk("t5_deq_restart", fifo_deq, 1);
        wait_drain("t5_drain");

        // 6: 18 words, then a flush with a handshake in the flush cycle
        begin_reset(1'b1);
        load(8'h50, 18, 1'b1);
        rst_n = 1'b1;
        wait_drain("t6_drain");
        next_cycle();
`ifdef FIFO_DRAIN_CNT_EN
        chk("t6_cnt_wrap", drain_count, 2);
`endif
        m_ready = 1'b0;
        load_word(8'h70, 1'b1);
        load_word(8'h71, 1'b0);
        next_cycle(); next_cycle(); next_cycle(); next_cycle();
        flush = 1'b1;
        m_ready = 1'b1;
        mid();
        chk("t6_flush_head", m_data, 8'h70);
        next_cycle();
        flush = 1'b0;
        for (int i = 0; i < 6; i++) next_cycle();
        chk("t6_no_extra", exp_q.size(), 0);
`ifdef FIFO_DRAIN_CNT_EN
        chk("t6_cnt_flush", drain_count, 3);
`endif
        rst_n = 1'b0;
        #1;
`ifdef FIFO_DRAIN_CNT_EN
        chk("t6_cnt_reset", drain_count, 0);
`endif
        chk("t6_valid_reset", m_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
